// File: rtl/button_debounce_irq_pkg.sv
// button_debounce_irq_pkg: debounce FSM state encoding and default debounce length
package button_debounce_irq_pkg;
  typedef enum logic [1:0] {REL, WAIT_P, PRS, WAIT_R} state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
endpackage

// File: rtl/dflop.sv
// dflop: D flip-flop cell with sync active-low reset; ports clk, rst, d, q
module dflop (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) q <= !rst ? 1'b0 : d;
endmodule

// File: rtl/sync2.sv
// sync2: two-flop synchronizer built from dflop cells; ports clk, rst (active-low), d (async), q
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic w_mid;
  dflop u_f0 (.clk(clk), .rst(rst), .d(d), .q(w_mid));
  dflop u_f1 (.clk(clk), .rst(rst), .d(w_mid), .q(q));
endmodule

// File: rtl/button_debounce_irq.sv
// button_debounce_irq: debounced button with press strobe and sticky irq; in clk, rst (sync active-low), i_btn_in, i_irq_ack; out o_btn_level, o_btn_pulse, o_irq, o_irq_lost
module button_debounce_irq
  import button_debounce_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_in,
  input  logic i_irq_ack,
  output logic o_btn_level,
  output logic o_btn_pulse,
  output logic o_irq,
  output logic o_irq_lost
);
  logic             w_btn_s, w_done, w_set, w_level;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_level, r_pulse, r_irq, r_lost;
  sync2 u_sync (.clk(clk), .rst(rst), .d(i_btn_in), .q(w_btn_s));
  assign w_done = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      REL:     w_next = w_btn_s ? WAIT_P : REL;
      WAIT_P:  w_next = !w_btn_s ? REL : (w_done ? PRS : WAIT_P);
      PRS:     w_next = w_btn_s ? PRS : WAIT_R;
      WAIT_R:  w_next = w_btn_s ? PRS : (w_done ? REL : WAIT_R);
      default: w_next = REL;
    endcase
    // counter only runs inside a pending state and restarts on every transition, so it cannot wrap
    w_cnt = (w_next != r_state) ? '0 : (r_state == WAIT_P || r_state == WAIT_R) ? r_cnt + 1'b1 : '0;
  end
  assign w_set   = r_state == WAIT_P && w_next == PRS;
  assign w_level = w_next == PRS || w_next == WAIT_R;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= REL;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_irq   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_level <= w_level;
      r_pulse <= w_set;
      // a new press beats a simultaneous ack, and an acked press is not counted as lost
      r_irq   <= w_set | (r_irq & ~i_irq_ack);
      r_lost  <= r_lost | (w_set & r_irq & ~i_irq_ack);
    end
  end
  assign o_btn_level = r_level;
  assign o_btn_pulse = r_pulse;
  assign o_irq       = r_irq;
  assign o_irq_lost  = r_lost;
endmodule

// File: tb/tb_button_debounce_irq.sv
// tb_button_debounce_irq: directed scoreboard bench for button_debounce_irq with DEBOUNCE_CYCLES=8
module tb_button_debounce_irq;
  logic clk = 0, rst = 0, btn = 0, ack = 0;
  logic lvl, pls, irq, lost;
  typedef struct {string tag; int v;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, npulse = 0, acc = 0;
  button_debounce_irq #(.DEBOUNCE_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_btn_in(btn), .i_irq_ack(ack),
    .o_btn_level(lvl), .o_btn_pulse(pls), .o_irq(irq), .o_irq_lost(lost)
  );
  always #5 clk = ~clk;
  function automatic int outs();
    return int'({lvl, pls, irq, lost});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(string t, int v);
    sb.push_back('{t, v});
  endtask
  task automatic check(int obs);
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", e.tag, obs, e.v);
    end
  endtask
  task automatic step_check(string t, int v);
    push(t, v);
    check(outs());
  endtask
  task automatic wait_level(string t, logic target, int lat);
    int n;
    n = 0;
    push(t, lat);
    do begin
      tick();
      n++;
      if (pls) npulse++;
    end while (lvl !== target && n < 40);
    check(n);
  endtask
  initial begin
    repeat (3) tick();
    step_check("reset", 0);
    rst = 1;
    tick();
    step_check("idle", 0);
    btn = 1;
    wait_level("press_lat", 1, 11);
    step_check("press_out", 4'b1110);
    tick();
    step_check("pulse_1cyc", 4'b1010);
    repeat (8) tick();
    step_check("held", 4'b1010);
    ack = 1;
    tick();
    ack = 0;
    step_check("ack_clr", 4'b1000);
    npulse = 0;
    btn = 0;
    wait_level("rel_lat", 0, 11);
    push("rel_nopulse", 0);
    check(npulse);
    step_check("rel_out", 0);
    ack = 1;
    tick();
    ack = 0;
    step_check("ack_idle", 0);
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      btn = ((i / 3) % 2) == 0;
      tick();
      acc |= outs();
    end
    btn = 0;
    repeat (15) begin
      tick();
      acc |= outs();
    end
    push("bounce", 0);
    check(acc);
    btn = 1;
    wait_level("p1_lat", 1, 11);
    step_check("p1", 4'b1110);
    btn = 0;
    wait_level("r1_lat", 0, 11);
    btn = 1;
    wait_level("p2_lat", 1, 11);
    step_check("p2_lost", 4'b1111);
    ack = 1;
    tick();
    ack = 0;
    step_check("ack_keep_lost", 4'b1001);
    btn = 0;
    wait_level("r2_lat", 0, 11);
    step_check("lost_sticky", 4'b0001);
    rst = 0;
    tick();
    rst = 1;
    step_check("rst_lost", 0);
    btn = 1;
    wait_level("p3_lat", 1, 11);
    step_check("p3", 4'b1110);
    btn = 0;
    wait_level("r3_lat", 0, 11);
    btn = 1;
    repeat (10) tick();
    ack = 1;
    tick();
    ack = 0;
    step_check("coincide", 4'b1110);
    tick();
    step_check("coincide_after", 4'b1010);
    btn = 0;
    wait_level("r4_lat", 0, 11);
    btn = 1;
    repeat (8) tick();
    rst = 0;
    tick();
    step_check("rst_mid", 0);
    rst = 1;
    wait_level("post_rst_lat", 1, 11);
    step_check("post_rst", 4'b1110);
    btn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_debounce_irq.md
BUTTON_DEBOUNCE_IRQ -- requirements
Module: button_debounce_irq

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 20, SHALL set the debounce counter width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-low reset, driven from the reset synchronizer output; low at a rising clk edge means reset.
REQ-005 btn_in  input  1  SHALL be the raw, asynchronous, bouncing push-button level, 1 = pressed.
REQ-006 irq_ack  input  1  SHALL be the interrupt acknowledge from the processor, a level sampled each cycle.
REQ-007 btn_level  output  1  SHALL be the debounced button level.
REQ-008 btn_pulse  output  1  SHALL be a one-cycle strobe on each accepted press.
REQ-009 irq  output  1  SHALL be the interrupt request, held until acknowledged.
REQ-010 irq_lost  output  1  SHALL be a sticky flag marking a press accepted while irq was already high.

Function
REQ-011 btn_in SHALL pass through a two-flop synchronizer before any other use; the output is btn_s.
REQ-012 FSM states SHALL be REL (released), WAIT_P (press pending), PRS (pressed) and WAIT_R (release pending).
REQ-013 REL SHALL go to WAIT_P when btn_s=1, clearing the counter.
REQ-014 WAIT_P SHALL return to REL when btn_s=0; otherwise it increments the counter.
REQ-015 WAIT_P SHALL go to PRS when the counter reaches DEBOUNCE_CYCLES-1 with btn_s=1.
REQ-016 PRS and WAIT_R SHALL mirror REQ-013 to REQ-015 with btn_s inverted, returning to REL after a stable release.
REQ-017 btn_level SHALL be 1 exactly in PRS and WAIT_R, registered.
REQ-018 Latency: a clean btn_in edge SHALL reach btn_level after 2 sync cycles plus DEBOUNCE_CYCLES+1 cycles.
REQ-019 btn_pulse SHALL be 1 for exactly one cycle, on the same edge that btn_level rises; release SHALL produce no pulse.
REQ-020 irq SHALL set on the edge btn_pulse asserts and clear on the edge after irq_ack=1 is sampled with no new pulse.
REQ-021 If a pulse and irq_ack coincide, set SHALL win: irq stays 1, and irq_lost is not set.
REQ-022 A pulse while irq=1 and irq_ack=0 SHALL set irq_lost; irq_lost clears only on reset.
REQ-023 Any bounce shorter than DEBOUNCE_CYCLES SHALL cause no change on any output.
REQ-024 The counter SHALL never wrap; it is cleared on every state transition.
REQ-025 irq_ack while irq=0 SHALL have no effect.

Reset
REQ-026 With rst=0 at a clk edge: state SHALL be REL, the counter 0, the synchronizer flops 0, and btn_level, btn_pulse, irq and irq_lost all 0.
REQ-027 Reset asserted mid-debounce or mid-interrupt SHALL abort it; a button held through reset SHALL be re-debounced from REL after release of reset.

Structure
REQ-028 A shared package SHALL hold the state enum (REL, WAIT_P, PRS, WAIT_R) and the DEBOUNCE_CYCLES default constant.
REQ-029 The two-flop synchronizer SHALL be a sub-module named sync2 (clk, rst, d, q), built from the codebase dflop cells.

Verification (DEBOUNCE_CYCLES=8)
REQ-030 Clean press held 20 cycles -> btn_level rises 11 cycles after the btn_in edge; btn_pulse is high for 1 cycle; irq=1.
REQ-031 btn_in toggles every 3 cycles for 30 cycles, then stays 0 -> all outputs stay 0 throughout.
REQ-032 Press, then irq_ack=1 for 1 cycle -> irq=0 on the next edge; release -> no pulse, and btn_level falls after 8 stable cycles.
REQ-033 Two accepted presses with no ack -> irq=1, irq_lost=1; then ack -> irq=0 while irq_lost stays 1.
REQ-034 irq_ack=1 on the same cycle as the second btn_pulse -> irq stays 1, irq_lost=0.
REQ-035 rst=0 at counter=5 in WAIT_P with btn_in held 1 -> all outputs 0; after rst=1, btn_level rises 11 cycles later.
